// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/execute control unit for the phase-1 bus datapath
//
// Ports:
//   clock, clear (async active-low), run, mem_ready, ir[31:0]  -- inputs
//   PCout PCin IncPC MARin MDRread MDRin MDRout IRin RYin RZinLo RZoutLo -- datapath strobes
//   reg_out_en/reg_out_sel, reg_in_en/reg_in_sel            -- general register bus drive / load
//   alu_op[4:0], instr_done, halted, bus_err, illegal, instr_count[CNT_W-1:0], state_dbg[2:0]
module control_sequencer #(
    parameter int CNT_W    = 16,
    parameter int WAIT_MAX = 15
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             run,
    input  logic             mem_ready,
    input  logic [31:0]      ir,
    output logic             PCout,
    output logic             PCin,
    output logic             IncPC,
    output logic             MARin,
    output logic             MDRread,
    output logic             MDRin,
    output logic             MDRout,
    output logic             IRin,
    output logic             RYin,
    output logic             RZinLo,
    output logic             RZoutLo,
    output logic             reg_out_en,
    output logic [3:0]       reg_out_sel,
    output logic             reg_in_en,
    output logic [3:0]       reg_in_sel,
    output logic [4:0]       alu_op,
    output logic             instr_done,
    output logic             halted,
    output logic             bus_err,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count,
    output logic [2:0]       state_dbg
);
    localparam int WW = $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        T0     = 3'd1,
        T1     = 3'd2,
        T2     = 3'd3,
        T3     = 3'd4,
        T4     = 3'd5,
        T5     = 3'd6,
        HALTED = 3'd7
    } state_t;

    state_t        state;
    logic [WW-1:0] wait_cnt;
    logic [4:0]    op;
    logic          alu3, unary, nop, hlt, bad_op, first_t1, t3, t4, t5;
    logic          unused_bits;

    assign op          = ir[31:27];
    assign alu3        = op >= 5'd3 && op <= 5'd11;
    assign unary       = op == 5'd17 || op == 5'd18;
    assign nop         = op == 5'd26;
    assign hlt         = op == 5'd27;
    assign bad_op      = !(alu3 || unary || nop || hlt);
    assign unused_bits = ^ir[14:0];
    assign t3          = state == T3;
    assign t4          = state == T4;
    assign t5          = state == T5;
    // The wait counter only advances on stalls, so zero marks the first T1 cycle.
    assign first_t1    = state == T1 && wait_cnt == '0;

    assign PCout       = state == T0;
    assign IncPC       = state == T0;
    assign MARin       = state == T0;
    assign PCin        = first_t1;
    assign MDRread     = state == T1;
    assign MDRin       = state == T1;
    assign MDRout      = state == T2;
    assign IRin        = state == T2;
    assign RYin        = t3 && alu3;
    assign RZinLo      = state == T0 || (t3 && unary) || (t4 && alu3);
    assign RZoutLo     = first_t1 || (t4 && unary) || (t5 && alu3);
    assign reg_out_en  = (t3 && (alu3 || unary)) || (t4 && alu3);
    assign reg_out_sel = !reg_out_en ? 4'd0 : t3 ? ir[22:19] : ir[18:15];
    assign reg_in_en   = (t4 && unary) || (t5 && alu3);
    assign reg_in_sel  = reg_in_en ? ir[26:23] : 4'd0;
    assign alu_op      = (t3 || t4) ? op : 5'd0;
    assign illegal     = t3 && bad_op;
    // A T4 that is not ALU3 closes the instruction so a corrupted IR cannot stall the sequencer.
    assign instr_done  = (t3 && (nop || bad_op)) || (t4 && !alu3) || t5;
    assign halted      = state == HALTED;
    assign state_dbg   = state;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            bus_err     <= 1'b0;
            instr_count <= '0;
        end else begin
            if (instr_done) instr_count <= instr_count + CNT_W'(1);
            case (state)
                IDLE:   state <= run ? T0 : IDLE;
                T0:     state <= T1;
                T1: begin
                    if (mem_ready) begin
                        state    <= T2;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WW'(WAIT_MAX - 1)) begin
                        state    <= HALTED;
                        bus_err  <= 1'b1;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                T2:     state <= T3;
                T3:     state <= instr_done ? (run ? T0 : IDLE) : hlt ? HALTED : T4;
                T4:     state <= instr_done ? (run ? T0 : IDLE) : T5;
                T5:     state <= run ? T0 : IDLE;
                HALTED: state <= HALTED;
            endcase
        end
    end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed self-checking bench for control_sequencer
module tb_control_sequencer;
    localparam logic [31:0] NEG  = 32'h8A2B8000;
    localparam logic [31:0] ADD  = 32'h1A2B8000;
    localparam logic [31:0] NOPI = 32'hD0000000;
    localparam logic [31:0] HLTI = 32'hD8000000;

    logic        clock, clear, run, mem_ready;
    logic [31:0] ir;
    logic        PCout, PCin, IncPC, MARin, MDRread, MDRin, MDRout, IRin, RYin, RZinLo, RZoutLo;
    logic        reg_out_en, reg_in_en, instr_done, halted, bus_err, illegal;
    logic [3:0]  reg_out_sel, reg_in_sel;
    logic [4:0]  alu_op;
    logic [2:0]  instr_count, state_dbg;
    logic [12:0] strb;
    int          n_cmp = 0, n_bad = 0;

    control_sequencer #(.CNT_W(3), .WAIT_MAX(15)) dut (
        .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready), .ir(ir),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRread(MDRread),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .RYin(RYin), .RZinLo(RZinLo),
        .RZoutLo(RZoutLo), .reg_out_en(reg_out_en), .reg_out_sel(reg_out_sel),
        .reg_in_en(reg_in_en), .reg_in_sel(reg_in_sel), .alu_op(alu_op),
        .instr_done(instr_done), .halted(halted), .bus_err(bus_err), .illegal(illegal),
        .instr_count(instr_count), .state_dbg(state_dbg)
    );

    // {PCout,PCin,IncPC,MARin,MDRread,MDRin,MDRout,IRin,RYin,RZinLo,RZoutLo,reg_out_en,reg_in_en}
    assign strb = {PCout, PCin, IncPC, MARin, MDRread, MDRin, MDRout, IRin, RYin, RZinLo,
                   RZoutLo, reg_out_en, reg_in_en};

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tk;
        @(posedge clock);
        #1;
    endtask

    initial begin
        clear = 0; run = 0; mem_ready = 1; ir = NEG;
        repeat (2) tk;
        chk("rst_state", state_dbg, 0); chk("rst_strb", strb, 0);
        chk("rst_cnt", instr_count, 0); chk("rst_err", bus_err, 0);
        clear = 1; run = 1;
        tk; chk("t0_state", state_dbg, 1); chk("t0_strb", strb, 'h1608); chk("t0_alu", alu_op, 0);
        tk; chk("t1_state", state_dbg, 2); chk("t1_strb", strb, 'h984);
        tk; chk("t2_state", state_dbg, 3); chk("t2_strb", strb, 'h60);
        tk; chk("neg_t3_state", state_dbg, 4); chk("neg_t3_strb", strb, 'h0A);
        chk("neg_t3_sel", reg_out_sel, 5); chk("neg_t3_alu", alu_op, 17);
        tk; chk("neg_t4_strb", strb, 'h05); chk("neg_t4_insel", reg_in_sel, 4);
        chk("neg_t4_done", instr_done, 1); chk("neg_t4_cnt", instr_count, 0);
        tk; chk("neg_end_state", state_dbg, 1); chk("neg_end_cnt", instr_count, 1);
        ir = ADD;
        repeat (3) tk;
        chk("add_t3_strb", strb, 'h12); chk("add_t3_sel", reg_out_sel, 5); chk("add_t3_done", instr_done, 0);
        tk; chk("add_t4_strb", strb, 'h0A); chk("add_t4_sel", reg_out_sel, 7);
        chk("add_t4_alu", alu_op, 3); chk("add_t4_done", instr_done, 0);
        tk; chk("add_t5_state", state_dbg, 6); chk("add_t5_strb", strb, 'h05);
        chk("add_t5_insel", reg_in_sel, 4); chk("add_t5_done", instr_done, 1);
        tk; chk("add_end_state", state_dbg, 1); chk("add_end_cnt", instr_count, 2);
        mem_ready = 0;
        tk; chk("w1_state", state_dbg, 2); chk("w1_strb", strb, 'h984);
        tk; chk("w2_strb", strb, 'h180);
        tk; chk("w3_strb", strb, 'h180);
        tk; chk("w4_state", state_dbg, 2); chk("w4_strb", strb, 'h180);
        mem_ready = 1;
        tk; chk("w_t2_state", state_dbg, 3);
        repeat (4) tk; chk("w_end_cnt", instr_count, 3); chk("w_end_state", state_dbg, 1);
        ir = 32'h0;
        repeat (3) tk; chk("ill_state", state_dbg, 4); chk("ill_pulse", illegal, 1); chk("ill_done", instr_done, 1);
        tk; chk("ill_end_state", state_dbg, 1); chk("ill_off", illegal, 0); chk("ill_cnt", instr_count, 4);
        ir = NOPI;
        repeat (12) tk; chk("nop_cnt7", instr_count, 7); chk("nop_state", state_dbg, 1);
        repeat (4) tk; chk("nop_wrap", instr_count, 0);
        ir = NEG;
        repeat (4) tk; chk("clr_pre_state", state_dbg, 5);
        clear = 0; #1;
        chk("clr_state", state_dbg, 0); chk("clr_strb", strb, 0);
        chk("clr_insel", reg_in_sel, 0); chk("clr_done", instr_done, 0);
        clear = 1; ir = NOPI;
        tk; chk("clr_restart", state_dbg, 1);
        repeat (4) tk; chk("nop2_cnt", instr_count, 1);
        ir = HLTI;
        repeat (3) tk; chk("hlt_t3_halted", halted, 0);
        tk; chk("hlt_state", state_dbg, 7); chk("hlt_flag", halted, 1);
        chk("hlt_cnt", instr_count, 1); chk("hlt_strb", strb, 0);
        tk; chk("hlt_stay", state_dbg, 7);
        clear = 0; #1; chk("hlt_clr", halted, 0);
        clear = 1; ir = NOPI; mem_ready = 0;
        tk; tk; repeat (14) tk;
        chk("w15_state", state_dbg, 2);
        mem_ready = 1; run = 0;
        tk; chk("w15_win", state_dbg, 3); chk("w15_err", bus_err, 0);
        tk; tk; chk("stop_idle", state_dbg, 0); chk("stop_cnt", instr_count, 1);
        run = 1; mem_ready = 0;
        tk; tk; repeat (14) tk;
        chk("to_pre_state", state_dbg, 2);
        tk; chk("to_state", state_dbg, 7); chk("to_err", bus_err, 1);
        chk("to_halted", halted, 1); chk("to_cnt", instr_count, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
